// File: rtl/div_nonrestoring_seq.sv
// div_nonrestoring_seq: iterative unsigned divider (DIVU/REMU path).
// Non-restoring add/subtract recurrence, one quotient bit per clock,
// sharing a single WIDTH+1 bit adder for both add and subtract.
// Optional feature macro: DIV_BY_ZERO_FLAG_EN (adds the dbz output and a
// one-cycle shortcut for a zero divisor).
module div_nonrestoring_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             clrn,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             ready
`ifdef DIV_BY_ZERO_FLAG_EN
  ,
  output logic             dbz
`endif
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

`ifdef DIV_BY_ZERO_FLAG_EN
  localparam bit SKIP_ZERO = 1'b1;
`else
  localparam bit SKIP_ZERO = 1'b0;
`endif

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH:0]   pr;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] dvs;

  logic [WIDTH:0]   pr_shift;
  logic [WIDTH:0]   addend;
  logic [WIDTH:0]   pr_next;
  logic             q_bit;
  logic [WIDTH-1:0] r_fix;

  // One recurrence step: subtraction is the adder with inverted divisor and carry-in 1
  always_comb begin
    pr_shift = {pr[WIDTH-1:0], dvd[WIDTH-1]};
    addend   = pr[WIDTH] ? {1'b0, dvs} : ~{1'b0, dvs};
    pr_next  = pr_shift + addend + {{WIDTH{1'b0}}, ~pr[WIDTH]};
    q_bit    = ~pr_next[WIDTH];
    r_fix    = pr_next[WIDTH] ? (pr_next[WIDTH-1:0] + dvs) : pr_next[WIDTH-1:0];
  end

  // Control FSM and datapath registers; q/r only change at completion
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
      busy  <= 1'b0;
      ready <= 1'b0;
      q     <= '0;
      r     <= '0;
      cnt   <= '0;
      pr    <= '0;
      dvd   <= '0;
      dvs   <= '0;
    end else begin
      ready <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            if (SKIP_ZERO && (b == '0)) begin
              q     <= '1;
              r     <= a;
              ready <= 1'b1;
            end else begin
              dvd   <= a;
              dvs   <= b;
              pr    <= '0;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= RUN;
            end
          end
        end
        RUN: begin
          pr  <= pr_next;
          dvd <= {dvd[WIDTH-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_ITER) begin
            q     <= {dvd[WIDTH-2:0], q_bit};
            r     <= r_fix;
            busy  <= 1'b0;
            ready <= 1'b1;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef DIV_BY_ZERO_FLAG_EN
  // Zero-divisor flag pulses alongside ready only for the shortcut completion
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      dbz <= 1'b0;
    end else begin
      dbz <= (state == IDLE) && start && (b == '0);
    end
  end
`endif

endmodule

// File: tb/tb_div_nonrestoring_seq.sv
// tb_div_nonrestoring_seq: directed and randomized checks of the divider
// against an arithmetic reference model (a / b, a % b).
module tb_div_nonrestoring_seq;

  localparam int W = 32;
`ifdef DIV_BY_ZERO_FLAG_EN
  localparam bit FEAT = 1'b1;
`else
  localparam bit FEAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         clrn;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] q;
  logic [W-1:0] r;
  logic         busy;
  logic         ready;
`ifdef DIV_BY_ZERO_FLAG_EN
  logic         dbz;
`endif

  int compared   = 0;
  int mismatched = 0;
  int lat;
  bit busy_ok;
  bit dbz_seen;

  div_nonrestoring_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .clrn (clrn),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .ready(ready)
`ifdef DIV_BY_ZERO_FLAG_EN
    ,
    .dbz  (dbz)
`endif
  );

  // Free-running clock, 10 time-unit period
  always #5 clk = ~clk;

  function automatic logic [W-1:0] ref_q(input logic [W-1:0] av, input logic [W-1:0] bv);
    return (bv == '0) ? {W{1'b1}} : av / bv;
  endfunction

  function automatic logic [W-1:0] ref_r(input logic [W-1:0] av, input logic [W-1:0] bv);
    return (bv == '0) ? av : av % bv;
  endfunction

  function automatic int ref_lat(input logic [W-1:0] bv);
    return (FEAT && bv == '0) ? 0 : W;
  endfunction

  task automatic check_output(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      $error("[TB] check %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Issue one start (called #1 after a rising edge) and wait, bounded, for ready
  task automatic apply_stimulus(input logic [W-1:0] av, input logic [W-1:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    busy_ok = 1'b1;
    while (!ready && lat < 200) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      @(posedge clk); #1;
      lat++;
    end
    if (busy !== 1'b0) busy_ok = 1'b0;
`ifdef DIV_BY_ZERO_FLAG_EN
    dbz_seen = dbz;
`else
    dbz_seen = 1'b0;
`endif
  endtask

  // Compare the completed operation against the model, then check ready drops
  task automatic finish_op(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv);
    check_output({tag, "_lat"}, 64'(lat), 64'(ref_lat(bv)));
    check_output({tag, "_q"}, 64'(q), 64'(ref_q(av, bv)));
    check_output({tag, "_r"}, 64'(r), 64'(ref_r(av, bv)));
    check_output({tag, "_busy"}, 64'(busy_ok), 64'd1);
    check_output({tag, "_dbz"}, 64'(dbz_seen), 64'(FEAT && bv == '0));
    @(posedge clk); #1;
    check_output({tag, "_ready_drop"}, 64'(ready), 64'd0);
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    bit           bad_ready;

    // Reset state
    clrn  = 1'b0;
    start = 1'b0;
    a     = '0;
    b     = '0;
    #12;
    check_output("rst_q", 64'(q), 64'd0);
    check_output("rst_r", 64'(r), 64'd0);
    check_output("rst_busy", 64'(busy), 64'd0);
    check_output("rst_ready", 64'(ready), 64'd0);
    clrn = 1'b1;
    @(posedge clk); #1;

    // Basic division and result hold across idle cycles
    apply_stimulus(32'd100, 32'd7);
    check_output("basic_q_lit", 64'(q), 64'd14);
    check_output("basic_r_lit", 64'(r), 64'd2);
    finish_op("basic", 32'd100, 32'd7);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check_output("hold_q", 64'(q), 64'd14);
      check_output("hold_r", 64'(r), 64'd2);
    end

    // Boundary operands
    apply_stimulus(32'hFFFF_FFFF, 32'd1);
    finish_op("max_by_1", 32'hFFFF_FFFF, 32'd1);
    apply_stimulus(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    finish_op("max_by_max", 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    apply_stimulus(32'd5, 32'd10);
    finish_op("a_lt_b", 32'd5, 32'd10);
    apply_stimulus(32'h1234_5678, 32'd0);
    check_output("dbz_q_lit", 64'(q), 64'hFFFF_FFFF);
    check_output("dbz_r_lit", 64'(r), 64'h1234_5678);
    finish_op("div_zero", 32'h1234_5678, 32'd0);

    // Start while busy is ignored; start during the ready cycle is accepted
    a = 32'd100;
    b = 32'd7;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("ign_busy", 64'(busy), 64'd1);
    lat = 5;
    while (!ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("ign_lat", 64'(lat), 64'(W));
    check_output("ign_q", 64'(q), 64'd14);
    check_output("ign_r", 64'(r), 64'd2);
    a = 32'd9;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check_output("b2b_busy", 64'(busy), 64'd1);
    check_output("b2b_ready", 64'(ready), 64'd0);
    check_output("b2b_hold_q", 64'(q), 64'd14);
    check_output("b2b_hold_r", 64'(r), 64'd2);
    lat = 0;
    while (!ready && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    check_output("b2b_lat", 64'(lat), 64'(W));
    check_output("b2b_q", 64'(q), 64'd3);
    check_output("b2b_r", 64'(r), 64'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of an operation
    a = 32'd1000;
    b = 32'd3;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) begin
      @(posedge clk); #1;
    end
    #2 clrn = 1'b0;
    #1;
    check_output("abort_q", 64'(q), 64'd0);
    check_output("abort_r", 64'(r), 64'd0);
    check_output("abort_busy", 64'(busy), 64'd0);
    check_output("abort_ready", 64'(ready), 64'd0);
    #4 clrn = 1'b1;
    bad_ready = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready !== 1'b0 || busy !== 1'b0) bad_ready = 1'b1;
    end
    check_output("abort_no_ready", 64'(bad_ready), 64'd0);
    apply_stimulus(32'd1000, 32'd3);
    check_output("fresh_q_lit", 64'(q), 64'd333);
    check_output("fresh_r_lit", 64'(r), 64'd1);
    finish_op("fresh", 32'd1000, 32'd3);

    // Randomized operand pairs against the arithmetic model
    for (int i = 0; i < 1000; i++) begin
      ra = $urandom;
      if ($urandom_range(0, 3) == 0) ra = ra >> $urandom_range(0, 31);
      rb = $urandom;
      if ($urandom_range(0, 2) == 0) rb = rb >> $urandom_range(8, 31);
      if (rb == '0) rb = 32'd1;
      apply_stimulus(ra, rb);
      check_output("rand_identity", (64'(q) * 64'(rb)) + 64'(r), 64'(ra));
      check_output("rand_r_lt_b", 64'(r < rb), 64'd1);
      finish_op("rand", ra, rb);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/div_nonrestoring_seq.md
Name: div_nonrestoring_seq

Overview:
- Iterative unsigned integer divider for the RISC-V integer pipeline (DIVU/REMU path).
- Runs a non-restoring add/subtract recurrence, one quotient bit per clock, on a single adder/subtractor.
- Subtraction is the inverse of the carry-lookahead addition used elsewhere in the datapath.
- Start/busy/ready handshake with the pipeline stall logic; results held until the next accepted start.

Parameters:
WIDTH, 32, operand/quotient/remainder width in bits; legal range 4..64.
CNT_W, $clog2(WIDTH)+1, iteration counter width; derived, not overridden.

Ports:
clk  input  1  rising-edge clock.
clrn  input  1  asynchronous active-low reset.
start  input  1  request; sampled at rising edge while busy==0.
a  input  WIDTH  dividend, captured on accepted start.
b  input  WIDTH  divisor, captured on accepted start.
q  output  WIDTH  quotient, registered.
r  output  WIDTH  remainder, registered, already corrected (0 <= r < b when b != 0).
busy  output  1  high while an operation is in progress.
ready  output  1  one-cycle pulse: q/r valid for the operation just completed.

Behaviour:
- Reset (clrn=0, asynchronous): state=IDLE, busy=0, ready=0, q=0, r=0, counter=0, internal partial remainder=0.
- States: IDLE and RUN.
  - IDLE -> RUN on an edge with start=1. Capture a, b; clear the partial remainder (WIDTH+1 bits, signed); counter=0; busy=1 after the edge.
  - RUN: each edge shifts the next dividend MSB into the partial remainder.
  - If the previous partial remainder is >= 0, subtract b; otherwise add b.
  - The quotient bit is the inverted sign of the result.
  - counter increments by 1 on each RUN edge.
- Final iteration (counter==WIDTH-1):
  - If the resulting partial remainder is negative, add b before registering r.
  - Load q and r; busy=0 and ready=1 after this edge; return to IDLE.
- Latency: start sampled at edge 0 -> ready high during the cycle after edge WIDTH (WIDTH cycles). With WIDTH=32, ready is high after edge 32.
- ready deasserts on the following edge unless a new completion occurs; it is never high while busy=1.
- start while busy=1: ignored. No queuing; a and b are not re-sampled.
- start in the same cycle that ready=1: accepted (busy is already 0). q and r hold the old result until the new operation completes.
- q and r change only at completion edges and reset. They are stable across IDLE for any number of cycles.
- Divide by zero (b=0, feature off): runs the full WIDTH cycles. The recurrence yields q = all ones and r = a. No exception is raised; the RISC-V result is produced naturally.
- a < b: q=0, r=a.
- clrn asserted mid-operation: abort immediately. Outputs go to reset values; no ready pulse follows release.
- All arithmetic is WIDTH+1 bits two's complement internally; no overflow is possible for unsigned operands.

Optional Feature:
- Macro: DIV_BY_ZERO_FLAG_EN.
- When defined:
  - Extra output port dbz (1 bit), reset value 0.
  - If the captured b==0, the block skips RUN and completes on the next edge (latency 1): q = all ones, r = a, ready=1, dbz=1 for that same cycle.
  - dbz=0 on every other completion, and it deasserts together with ready.
- When undefined: no dbz port. Divide by zero takes the full WIDTH cycles with the identical q/r values.

Test Plan:
- WIDTH=32, start with a=100, b=7 -> busy for 32 cycles; ready pulses once after edge 32; q=14, r=2; q/r hold for 10 further idle cycles.
- a=0xFFFFFFFF, b=1 -> q=0xFFFFFFFF, r=0. Then a=0xFFFFFFFF, b=0xFFFFFFFF -> q=1, r=0. Then a=5, b=10 -> q=0, r=5.
- b=0, a=0x12345678:
  - feature off -> after 32 cycles q=0xFFFFFFFF, r=0x12345678.
  - DIV_BY_ZERO_FLAG_EN on -> ready and dbz after 1 cycle, same q/r.
- Start a=100, b=7; pulse start with a=9, b=3 at cycle 5 -> ignored; result q=14, r=2. Then start a=9, b=3 in the ready cycle -> accepted; 32 cycles later q=3, r=0.
- Start a=1000, b=3; drive clrn=0 at cycle 10 -> busy, ready, q, r drop to 0 immediately. After release, no ready pulse for 40 cycles. A fresh start of 1000/3 gives q=333, r=1.
- Randomized 1000 pairs against a reference model (b != 0): q*b + r == a and r < b every time; exactly one ready pulse per accepted start.
